cic_decimator: RTL and testbench

- Complex CIC decimation filter directly downstream of the Mixer. Consumes the mixer's COMPLEX_STREAM output: 18-bit signed I/Q with a Valid strobe.
- Low-pass filters and decimates both rails by R = 2**RATE_LOG2 using STAGES integrator/comb pairs.
- Drives a COMPLEX_STREAM at the reduced rate to later channel filters.

---
 rtl/cic_decimator_pkg.sv | 16 +
 rtl/cic_decimator_rail.sv | 94 +++++++++
 rtl/cic_decimator.sv | 63 ++++++
 tb/tb_cic_decimator.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/cic_decimator_pkg.sv
// Shared types and constants for the complex CIC decimator.
package cic_decimator_pkg;

  localparam int unsigned SAMPLE_W       = 18;
  localparam int unsigned CIC_MAX_STAGES = 6;

  localparam logic signed [SAMPLE_W-1:0] SAMPLE_MAX = 18'sd131071;
  localparam logic signed [SAMPLE_W-1:0] SAMPLE_MIN = -18'sd131072;

  typedef struct packed {
    logic signed [SAMPLE_W-1:0] I;
    logic signed [SAMPLE_W-1:0] Q;
    logic                       Valid;
  } COMPLEX_STREAM;

endpackage

// File: rtl/cic_decimator_rail.sv
// One CIC rail: integrator chain, strobe-gated comb pipeline, round and saturate.
module cic_rail
  import cic_decimator_pkg::*;
#(
  parameter int unsigned STAGES    = 3,
  parameter int unsigned RATE_LOG2 = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic signed [SAMPLE_W-1:0] sample_i,
  input  logic                       valid_i,
  input  logic [STAGES+1:0]          stb_i,
  output logic signed [SAMPLE_W-1:0] data_o
);

  localparam int unsigned GROWTH = STAGES * RATE_LOG2;
  localparam int unsigned W      = SAMPLE_W + GROWTH;
  localparam int unsigned RW     = SAMPLE_W + 1;

  localparam logic signed [W:0]    HALF = {{W{1'b0}}, 1'b1} << (GROWTH - 1);
  localparam logic signed [RW-1:0] RMAX = RW'(SAMPLE_MAX);
  localparam logic signed [RW-1:0] RMIN = RW'(SAMPLE_MIN);

  logic signed [W-1:0]        integ_q [STAGES];
  logic signed [W-1:0]        integ_d [STAGES];
  logic signed [W-1:0]        comb_q  [STAGES];
  logic signed [W-1:0]        dly_q   [STAGES];
  logic signed [W-1:0]        comb_x  [STAGES];
  logic signed [W-1:0]        acc;
  logic signed [W:0]          rsum;
  logic signed [RW-1:0]       rnd_q, rnd_d;
  logic signed [SAMPLE_W-1:0] data_q, sat_d;

  // Integrators cascade within one cycle, so each stage sees this cycle's sum.
  always_comb begin
    acc = {{GROWTH{sample_i[SAMPLE_W-1]}}, sample_i};
    for (int unsigned k = 0; k < STAGES; k++) begin
      acc        = acc + integ_q[k];
      integ_d[k] = acc;
    end
  end

  always_comb begin
    comb_x[0] = integ_q[STAGES-1];
    for (int unsigned k = 1; k < STAGES; k++) begin
      comb_x[k] = comb_q[k-1];
    end
  end

  always_comb begin
    rsum  = {comb_q[STAGES-1][W-1], comb_q[STAGES-1]} + HALF;
    rnd_d = RW'(rsum >>> GROWTH);
    if (rnd_q > RMAX) begin
      sat_d = SAMPLE_MAX;
    end else if (rnd_q < RMIN) begin
      sat_d = SAMPLE_MIN;
    end else begin
      sat_d = rnd_q[SAMPLE_W-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        integ_q[k] <= '0;
        comb_q[k]  <= '0;
        dly_q[k]   <= '0;
      end
      rnd_q  <= '0;
      data_q <= '0;
    end else begin
      if (valid_i) begin
        for (int unsigned k = 0; k < STAGES; k++) begin
          integ_q[k] <= integ_d[k];
        end
      end
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (stb_i[k]) begin
          comb_q[k] <= comb_x[k] - dly_q[k];
          dly_q[k]  <= comb_x[k];
        end
      end
      if (stb_i[STAGES]) begin
        rnd_q <= rnd_d;
      end
      if (stb_i[STAGES+1]) begin
        data_q <= sat_d;
      end
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/cic_decimator.sv
// Complex CIC decimator top: shared sample counter, dump strobe pipeline, two rails.
module cic_decimator
  import cic_decimator_pkg::*;
#(
  parameter int unsigned STAGES    = 3,
  parameter int unsigned RATE_LOG2 = 3
) (
  input  logic          ipClk,
  input  logic          ipReset,
  input  COMPLEX_STREAM ipInput,
  output COMPLEX_STREAM opOutput
);

  localparam logic [RATE_LOG2-1:0] CNT_LAST = '1;

  logic [RATE_LOG2-1:0]       cnt_q, cnt_d;
  logic                       dump;
  logic [STAGES+1:0]          stb_q, stb_d;
  logic                       valid_q, valid_d;
  logic signed [SAMPLE_W-1:0] i_data, q_data;

  always_comb begin
    dump    = ipInput.Valid && (cnt_q == CNT_LAST);
    cnt_d   = ipInput.Valid ? cnt_q + 1'b1 : cnt_q;
    stb_d   = {stb_q[STAGES:0], dump};
    valid_d = stb_q[STAGES+1];
  end

  always_ff @(posedge ipClk) begin
    if (!ipReset) begin
      cnt_q   <= '0;
      stb_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      stb_q   <= stb_d;
      valid_q <= valid_d;
    end
  end

  cic_rail #(.STAGES(STAGES), .RATE_LOG2(RATE_LOG2)) u_rail_i (
    .clk_i   (ipClk),
    .rst_ni  (ipReset),
    .sample_i(ipInput.I),
    .valid_i (ipInput.Valid),
    .stb_i   (stb_q),
    .data_o  (i_data)
  );

  cic_rail #(.STAGES(STAGES), .RATE_LOG2(RATE_LOG2)) u_rail_q (
    .clk_i   (ipClk),
    .rst_ni  (ipReset),
    .sample_i(ipInput.Q),
    .valid_i (ipInput.Valid),
    .stb_i   (stb_q),
    .data_o  (q_data)
  );

  assign opOutput.I     = i_data;
  assign opOutput.Q     = q_data;
  assign opOutput.Valid = valid_q;

endmodule

// File: tb/tb_cic_decimator.sv
// Directed self-checking bench for cic_decimator at STAGES=3, R=8.
module tb_cic_decimator;
  import cic_decimator_pkg::*;

  localparam int unsigned ST  = 3;
  localparam int unsigned RL  = 3;
  localparam int unsigned R   = 8;
  localparam int unsigned LAT = ST + 2;

  logic          clk = 1'b0;
  logic          rst_n;
  COMPLEX_STREAM din;
  COMPLEX_STREAM dout;

  always #5 clk = ~clk;

  cic_decimator #(.STAGES(ST), .RATE_LOG2(RL)) dut (
    .ipClk   (clk),
    .ipReset (rst_n),
    .ipInput (din),
    .opOutput(dout)
  );

  typedef struct {
    int          i;
    int          q;
    int unsigned c;
  } out_t;

  int unsigned cyc = 0;
  out_t        outq[$];
  int unsigned vcyc[$];
  int          passed = 0;
  int          total  = 0;
  logic        prev_v = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic signed [39:0] obs,
                       input logic signed [39:0] exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
  endtask

  always @(negedge clk) begin
    if (dout.Valid === 1'b1) begin
      check("no_back_to_back", prev_v, 0);
      outq.push_back('{int'(dout.I), int'(dout.Q), cyc});
    end
    prev_v = (dout.Valid === 1'b1);
  end

  task automatic drive(input logic v, input int i, input int q);
    @(negedge clk);
    din.Valid = v;
    din.I     = 18'(i);
    din.Q     = 18'(q);
    @(posedge clk);
    #1;
    if (v) vcyc.push_back(cyc);
  endtask

  // Reset held n edges with a live input; outputs must read zero throughout.
  task automatic do_reset(input int unsigned n);
    @(negedge clk);
    rst_n     = 1'b0;
    din.Valid = 1'b1;
    din.I     = 18'sd5000;
    din.Q     = 18'sd5000;
    repeat (n) begin
      @(posedge clk);
      #1;
      check("reset_out_zero", dout, 0);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    din.Valid = 1'b0;
    outq.delete();
    vcyc.delete();
  endtask

  task automatic check_run(input string tag, input int unsigned nout,
                           input int ei, input int eq);
    int unsigned bad_lat = 0;
    int unsigned bad_val = 0;
    check({tag, "_count"}, outq.size(), nout);
    for (int unsigned k = 0; k < outq.size() && k < nout; k++) begin
      if (R*k + R - 1 >= vcyc.size() || outq[k].c != vcyc[R*k+R-1] + LAT) bad_lat++;
      if (k >= ST - 1 && (outq[k].i != ei || outq[k].q != eq)) bad_val++;
    end
    check({tag, "_latency_errs"}, bad_lat, 0);
    check({tag, "_settled_errs"}, bad_val, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    din   = '0;
    rst_n = 1'b1;

    // Reset hold, then DC continuous straight after release
    do_reset(5);
    for (int n = 0; n < 48; n++) drive(1'b1, 1000, -1000);
    repeat (12) drive(1'b0, 0, 0);
    check_run("dc_cont", 6, 1000, -1000);
    check("dc_first_latency", outq[0].c - vcyc[7], LAT);
    check("dc_tr0_i", outq[0].i, 234);
    check("dc_tr0_q", outq[0].q, -234);
    check("dc_tr1_i", outq[1].i, 891);
    check("dc_tr1_q", outq[1].q, -891);
    check("dc_hold_valid", dout.Valid, 0);
    check("dc_hold_i", dout.I, 1000);
    check("dc_hold_q", dout.Q, -1000);

    // Gapped: one valid in three
    do_reset(2);
    for (int n = 0; n < 48; n++) begin
      drive(1'b1, 1000, -1000);
      drive(1'b0, 7, 7);
      drive(1'b0, 7, 7);
    end
    repeat (12) drive(1'b0, 0, 0);
    check_run("gapped", 6, 1000, -1000);
    check("gapped_spacing", outq[1].c - outq[0].c, 24);

    // Full scale: integrators wrap many times
    do_reset(2);
    for (int n = 0; n < 20000; n++) drive(1'b1, 131071, -131072);
    repeat (12) drive(1'b0, 0, 0);
    check_run("fullscale", 2500, 131071, -131072);

    // Nyquist tone on I only
    do_reset(2);
    for (int n = 0; n < 64; n++) drive(1'b1, (n % 2 == 0) ? 8192 : -8192, 0);
    repeat (12) drive(1'b0, 0, 0);
    check_run("nyquist", 8, 0, 0);

    // Reset after 13 valids: the counter and transient must restart
    do_reset(2);
    for (int n = 0; n < 13; n++) drive(1'b1, 1000, -1000);
    check("pre_reset_pulse", dout.Valid, 1);
    check("pre_reset_i", dout.I, 234);
    do_reset(1);
    for (int n = 0; n < 8; n++) drive(1'b1, 1000, -1000);
    repeat (8) drive(1'b0, 0, 0);
    check("restart_count", outq.size(), 1);
    check("restart_latency", outq[0].c - vcyc[7], LAT);
    check("restart_i", outq[0].i, 234);
    check("restart_q", outq[0].q, -234);

    // Reset one cycle after a dump kills the in-flight output
    for (int n = 0; n < 8; n++) drive(1'b1, 1000, -1000);
    do_reset(1);
    repeat (12) drive(1'b0, 0, 0);
    check("killed_count", outq.size(), 0);
    for (int n = 0; n < 8; n++) drive(1'b1, 1000, -1000);
    repeat (8) drive(1'b0, 0, 0);
    check("after_kill_count", outq.size(), 1);
    check("after_kill_latency", outq[0].c - vcyc[7], LAT);
    check("after_kill_i", outq[0].i, 234);
    check("after_kill_q", outq[0].q, -234);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
